alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Sequencer that shares the single 32-bit structural ALU (`alu`) between two requesters. Each request carries two operands and a 3-bit command. The arbiter grants requests round-robin and registers the operands onto the ALU inputs. Because the ALU is a gate-delay combinational datapath, it then waits a fixed number of settle cycles before capturing result, carryout, zero and overflow into a response register with a valid/ready handshake.

## Interface
- `SETTLE_CYCLES`, default 4: clock cycles the ALU inputs are held stable before its outputs are captured; legal range 1..255.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: reset, asynchronous and active-high.
- `req0_valid` in 1: requester 0 has a request.
- `req0_ready` out 1: requester 0 is accepted this cycle.
- `req0_a` in 32: requester 0 operand A.
- `req0_b` in 32: requester 0 operand B.
- `req0_cmd` in 3: requester 0 ALU command.
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_cmd`: same widths and meanings for requester 1.
- `rsp_valid` out 1: response registers hold a completed result.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: index of the requester that owns the response.
- `rsp_result` out 32: captured ALU result.
- `rsp_carryout`, `rsp_zero`, `rsp_overflow` out 1 each: captured ALU flags.
- `alu_operandA`, `alu_operandB` out 32 each: registered drive to the ALU operand inputs.
- `alu_command` out 3: registered drive to the ALU command input.
- `alu_result` in 32: ALU result output.
- `alu_carryout`, `alu_zero`, `alu_overflow` in 1 each: ALU flag outputs.

## Operation
- Command encoding is passed through unchanged: 000 ADD, 001 SUB, 010 XOR, 011 SLT, 100 AND, 101 NAND, 110 NOR, 111 OR. The arbiter does not interpret commands.
- FSM states: IDLE, SETTLE, RESP. Reset state is IDLE.
- **Grant rule.** Grant is combinational and active only in IDLE.
  - Only one `reqN_valid` high: grant N.
  - Both high: grant the requester not served last (`last_grant` register, reset to 1, so req0 wins the first tie).
- **Ready rule.** `reqN_ready` = IDLE && grant==N. It is never high outside IDLE, and never high for both requesters at once.
- **IDLE, on accept** (valid && ready):
  - Load `alu_operandA`/`alu_operandB`/`alu_command` from the granted request.
  - Record the owner id and set `last_grant` = N.
  - Load the 8-bit settle counter with SETTLE_CYCLES-1 and go to SETTLE.
- **SETTLE:** ALU drive registers are held.
  - Counter != 0: decrement.
  - Counter == 0: capture `alu_result` and the three flags into the `rsp_*` registers, set `rsp_id` from the owner, and go to RESP.
- **RESP:** `rsp_valid`=1. The ALU drive registers stay held, so captured and live values agree.
  - On `rsp_ready`=1, go to IDLE.
  - No new request is accepted in the same cycle as the response handshake.
- `rsp_*` data is stable while `rsp_valid`=1 and `rsp_ready`=0; hold may be indefinite.
- Request payload is sampled only on the accept edge. Later changes on request inputs have no effect on an in-flight operation.

## Timing
- Reset value of every output is 0 (all `alu_*` drives, all `rsp_*`, both `reqN_ready`). `reqN_ready` may rise combinationally in the first IDLE cycle after reset deasserts.
- **Latency.** Accept handshake in cycle 0. SETTLE occupies cycles 1..SETTLE_CYCLES. The capture edge ends cycle SETTLE_CYCLES. `rsp_valid` is high from cycle SETTLE_CYCLES+1.
- **Throughput.** With `rsp_ready` held at 1, one operation completes every SETTLE_CYCLES+2 cycles: accept, settle, response, then back to IDLE.
- **SETTLE_CYCLES=1.** Counter loads 0 and capture occurs at the end of cycle 1.
- **Both valid while in SETTLE/RESP.** No ready is asserted. On return to IDLE, round-robin applies against `last_grant`.
- **Reset mid-operation.** Any in-flight or pending response is discarded. No response is ever issued for it. All registers return to reset values immediately (asynchronous).
- A requester that drops `valid` before `ready` loses nothing. Valid/ready is level-based with no latching of unaccepted requests.

## Test plan
- **Single ADD.** SETTLE_CYCLES=4, req0 ADD A=0x00000005 B=0x00000003 -> `req0_ready` in cycle 0; `rsp_valid` rises in cycle 5 with `rsp_result`=0x00000008, `rsp_id`=0, carryout=0, zero=0, overflow=0.
- **Tie and round-robin.** Both valid at once: req0 SUB 7-7, req1 SLT A=0xFFFFFFFF B=0x00000001 -> first grant to req0 (`rsp_result`=0, `rsp_zero`=1, `rsp_carryout`=1); second grant to req1 (`rsp_result`=1, `rsp_id`=1); a third tie grants req0.
- **Overflow capture.** req1 ADD A=0x7FFFFFFF B=0x00000001 -> `rsp_result`=0x80000000, `rsp_overflow`=1, `rsp_id`=1.
- **Backpressure.** Hold `rsp_ready`=0 for 10 cycles in RESP while req0 stays valid -> `rsp_*` stable, `req0_ready` remains 0. Raise `rsp_ready` -> IDLE next cycle, req0 accepted in that cycle.
- **Reset mid-SETTLE.** Assert `reset` in cycle 2 of an operation -> all outputs 0 immediately; after release no `rsp_valid` for the dropped request, and the next tie is granted to req0.
- **SETTLE_CYCLES=1.** Back-to-back req0 NOR 0,0 with `rsp_ready`=1 -> `rsp_result`=0xFFFFFFFF, `rsp_valid` in cycle 2, accepts every 3 cycles.

Source files
------------

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one combinational 32-bit ALU between two requesters.
//               Requests are granted round-robin, their operands and command
//               are registered onto the ALU inputs, the ALU is given
//               SETTLE_CYCLES clocks to settle, and its outputs are captured
//               into a valid/ready response register.
// Ports       : clk, reset (async, active-high)
//               req0_* / req1_* : valid/ready request, operands a/b, cmd
//               rsp_*           : valid/ready response, id, result, flags
//               alu_operandA/B, alu_command : registered ALU drive
//               alu_result, alu_carryout/zero/overflow : ALU outputs
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [2:0]  req0_cmd,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [2:0]  req1_cmd,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_carryout,
  output logic        rsp_zero,
  output logic        rsp_overflow,
  output logic [31:0] alu_operandA,
  output logic [31:0] alu_operandB,
  output logic [2:0]  alu_command,
  input  logic [31:0] alu_result,
  input  logic        alu_carryout,
  input  logic        alu_zero,
  input  logic        alu_overflow
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        owner_q, owner_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] opa_q, opa_d;
  logic [31:0] opb_q, opb_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [31:0] res_q, res_d;
  logic        carry_q, carry_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic        rid_q, rid_d;

  logic grant;
  logic rdy0;
  logic rdy1;

  // On a tie the requester not served last wins; otherwise whoever is valid.
  // Ready is gated by reset so every output reads 0 while reset is held.
  always_comb begin
    grant = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
    rdy0  = (state_q == ST_IDLE) && !reset && req0_valid && !grant;
    rdy1  = (state_q == ST_IDLE) && !reset && req1_valid &&  grant;
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    opa_d        = opa_q;
    opb_d        = opb_q;
    cmd_d        = cmd_q;
    res_d        = res_q;
    carry_d      = carry_q;
    zero_d       = zero_q;
    ovf_d        = ovf_q;
    rid_d        = rid_q;
    case (state_q)
      ST_IDLE: begin
        if (rdy0 || rdy1) begin
          opa_d        = rdy1 ? req1_a   : req0_a;
          opb_d        = rdy1 ? req1_b   : req0_b;
          cmd_d        = rdy1 ? req1_cmd : req0_cmd;
          owner_d      = rdy1;
          last_grant_d = rdy1;
          cnt_d        = SETTLE_LOAD;
          state_d      = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q != 8'd0) begin
          cnt_d = cnt_q - 8'd1;
        end else begin
          res_d   = alu_result;
          carry_d = alu_carryout;
          zero_d  = alu_zero;
          ovf_d   = alu_overflow;
          rid_d   = owner_q;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        // ALU drive stays held here so the live ALU outputs still match.
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= 8'd0;
      opa_q        <= 32'd0;
      opb_q        <= 32'd0;
      cmd_q        <= 3'd0;
      res_q        <= 32'd0;
      carry_q      <= 1'b0;
      zero_q       <= 1'b0;
      ovf_q        <= 1'b0;
      rid_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      opa_q        <= opa_d;
      opb_q        <= opb_d;
      cmd_q        <= cmd_d;
      res_q        <= res_d;
      carry_q      <= carry_d;
      zero_q       <= zero_d;
      ovf_q        <= ovf_d;
      rid_q        <= rid_d;
    end
  end

  assign req0_ready   = rdy0;
  assign req1_ready   = rdy1;
  assign rsp_valid    = (state_q == ST_RESP);
  assign rsp_id       = rid_q;
  assign rsp_result   = res_q;
  assign rsp_carryout = carry_q;
  assign rsp_zero     = zero_q;
  assign rsp_overflow = ovf_q;
  assign alu_operandA = opa_q;
  assign alu_operandB = opb_q;
  assign alu_command  = cmd_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter. A behavioural
//               ALU sits on each DUT's ALU port; one DUT uses
//               SETTLE_CYCLES=4, a second uses SETTLE_CYCLES=1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- DUT with SETTLE_CYCLES=4 ----------------
  logic        req0_valid = 0, req1_valid = 0, rsp_ready = 0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
  logic [2:0]  req0_cmd = 0, req1_cmd = 0;
  logic        rsp_valid, rsp_id, rsp_carryout, rsp_zero, rsp_overflow;
  logic [31:0] rsp_result, alu_operandA, alu_operandB, alu_result;
  logic [2:0]  alu_command;
  logic        alu_carryout, alu_zero, alu_overflow;

  // ---------------- DUT with SETTLE_CYCLES=1 ----------------
  logic        s1_req0_valid = 0, s1_rsp_ready = 0;
  logic        s1_req0_ready, s1_req1_ready;
  logic [31:0] s1_req0_a = 0, s1_req0_b = 0;
  logic [2:0]  s1_req0_cmd = 0;
  logic        s1_rsp_valid, s1_rsp_id, s1_rsp_carryout, s1_rsp_zero, s1_rsp_overflow;
  logic [31:0] s1_rsp_result, s1_alu_operandA, s1_alu_operandB, s1_alu_result;
  logic [2:0]  s1_alu_command;
  logic        s1_alu_carryout, s1_alu_zero, s1_alu_overflow;

  // Behavioural ALU: {carryout, zero, overflow, result}
  function automatic logic [34:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] c);
    logic [32:0] s;
    logic [31:0] r;
    logic        co;
    logic        ov;
    s = 33'd0; r = 32'd0; co = 1'b0; ov = 1'b0;
    case (c)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0]; co = s[32];
        ov = (a[31] == b[31]) && (r[31] != a[31]);
      end
      3'd1: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0]; co = s[32];
        ov = (a[31] != b[31]) && (r[31] != a[31]);
      end
      3'd2: r = a ^ b;
      3'd3: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: r = a & b;
      3'd5: r = ~(a & b);
      3'd6: r = ~(a | b);
      default: r = a | b;
    endcase
    return {co, (r == 32'd0), ov, r};
  endfunction

  always_comb {alu_carryout, alu_zero, alu_overflow, alu_result} =
    alu_model(alu_operandA, alu_operandB, alu_command);
  always_comb {s1_alu_carryout, s1_alu_zero, s1_alu_overflow, s1_alu_result} =
    alu_model(s1_alu_operandA, s1_alu_operandB, s1_alu_command);

  alu_arbiter #(.SETTLE_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_carryout(rsp_carryout),
    .rsp_zero(rsp_zero), .rsp_overflow(rsp_overflow),
    .alu_operandA(alu_operandA), .alu_operandB(alu_operandB),
    .alu_command(alu_command), .alu_result(alu_result),
    .alu_carryout(alu_carryout), .alu_zero(alu_zero), .alu_overflow(alu_overflow)
  );

  alu_arbiter #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset),
    .req0_valid(s1_req0_valid), .req0_ready(s1_req0_ready),
    .req0_a(s1_req0_a), .req0_b(s1_req0_b), .req0_cmd(s1_req0_cmd),
    .req1_valid(1'b0), .req1_ready(s1_req1_ready),
    .req1_a(32'd0), .req1_b(32'd0), .req1_cmd(3'd0),
    .rsp_valid(s1_rsp_valid), .rsp_ready(s1_rsp_ready), .rsp_id(s1_rsp_id),
    .rsp_result(s1_rsp_result), .rsp_carryout(s1_rsp_carryout),
    .rsp_zero(s1_rsp_zero), .rsp_overflow(s1_rsp_overflow),
    .alu_operandA(s1_alu_operandA), .alu_operandB(s1_alu_operandB),
    .alu_command(s1_alu_command), .alu_result(s1_alu_result),
    .alu_carryout(s1_alu_carryout), .alu_zero(s1_alu_zero),
    .alu_overflow(s1_alu_overflow)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 40) begin
      tick();
      n++;
    end
    check_eq("rsp_timeout", {31'd0, rsp_valid}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---------------- reset state ----------------
    req0_valid = 1; req1_valid = 1;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_rdy0", {31'd0, req0_ready}, 32'd0);
    check_eq("rst_rdy1", {31'd0, req1_ready}, 32'd0);
    check_eq("rst_rspv", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_opa", alu_operandA, 32'd0);
    check_eq("rst_res", rsp_result, 32'd0);
    req0_valid = 0; req1_valid = 0;
    reset = 0;

    // ---------------- single ADD, latency ----------------
    req0_a = 32'h5; req0_b = 32'h3; req0_cmd = 3'd0; req0_valid = 1;
    #1;
    check_eq("add_rdy0", {31'd0, req0_ready}, 32'd1);
    tick();                       // cycle 1
    req0_valid = 0;
    check_eq("add_opa", alu_operandA, 32'h5);
    check_eq("add_c1_v", {31'd0, rsp_valid}, 32'd0);
    repeat (3) tick();            // cycle 4
    check_eq("add_c4_v", {31'd0, rsp_valid}, 32'd0);
    tick();                       // cycle 5
    check_eq("add_c5_v", {31'd0, rsp_valid}, 32'd1);
    check_eq("add_res", rsp_result, 32'h8);
    check_eq("add_id", {31'd0, rsp_id}, 32'd0);
    check_eq("add_flags", {29'd0, rsp_carryout, rsp_zero, rsp_overflow}, 32'd0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    check_eq("add_done", {31'd0, rsp_valid}, 32'd0);

    // ---------------- tie and round-robin ----------------
    reset = 1; #1; reset = 0;
    req0_a = 32'd7; req0_b = 32'd7; req0_cmd = 3'd1;
    req1_a = 32'hFFFFFFFF; req1_b = 32'h1; req1_cmd = 3'd3;
    req0_valid = 1; req1_valid = 1;
    #1;
    check_eq("tie1_rdy0", {31'd0, req0_ready}, 32'd1);
    check_eq("tie1_rdy1", {31'd0, req1_ready}, 32'd0);
    tick();
    check_eq("settle_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
    wait_rsp();
    check_eq("tie1_res", rsp_result, 32'd0);
    check_eq("tie1_zero", {31'd0, rsp_zero}, 32'd1);
    check_eq("tie1_carry", {31'd0, rsp_carryout}, 32'd1);
    check_eq("tie1_id", {31'd0, rsp_id}, 32'd0);
    check_eq("resp_rdy", {30'd0, req0_ready, req1_ready}, 32'd0);
    rsp_ready = 1;
    tick();
    check_eq("tie2_rdy1", {31'd0, req1_ready}, 32'd1);
    check_eq("tie2_rdy0", {31'd0, req0_ready}, 32'd0);
    rsp_ready = 0;
    tick();
    wait_rsp();
    check_eq("tie2_res", rsp_result, 32'd1);
    check_eq("tie2_id", {31'd0, rsp_id}, 32'd1);
    rsp_ready = 1;
    tick();
    check_eq("tie3_rdy0", {31'd0, req0_ready}, 32'd1);
    check_eq("tie3_rdy1", {31'd0, req1_ready}, 32'd0);
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    tick();

    // ---------------- overflow capture ----------------
    req1_a = 32'h7FFFFFFF; req1_b = 32'h1; req1_cmd = 3'd0; req1_valid = 1;
    #1;
    check_eq("ovf_rdy1", {31'd0, req1_ready}, 32'd1);
    tick();
    req1_valid = 0;
    req1_a = 32'h0;               // later payload changes must not matter
    wait_rsp();
    check_eq("ovf_res", rsp_result, 32'h80000000);
    check_eq("ovf_ovf", {31'd0, rsp_overflow}, 32'd1);
    check_eq("ovf_carry", {31'd0, rsp_carryout}, 32'd0);
    check_eq("ovf_id", {31'd0, rsp_id}, 32'd1);

    // ---------------- backpressure ----------------
    req0_a = 32'hFFFF0000; req0_b = 32'h0F0F0F0F; req0_cmd = 3'd4; req0_valid = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("bp_res", rsp_result, 32'h80000000);
      check_eq("bp_ovf", {31'd0, rsp_overflow}, 32'd1);
      check_eq("bp_rdy0", {31'd0, req0_ready}, 32'd0);
    end
    rsp_ready = 1;
    tick();
    check_eq("bp_idle_v", {31'd0, rsp_valid}, 32'd0);
    check_eq("bp_acc", {31'd0, req0_ready}, 32'd1);
    rsp_ready = 0;
    tick();
    req0_valid = 0;
    check_eq("bp_opa", alu_operandA, 32'hFFFF0000);
    wait_rsp();
    check_eq("bp2_res", rsp_result, 32'h0F0F0000);
    check_eq("bp2_id", {31'd0, rsp_id}, 32'd0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0;

    // ---------------- reset mid-SETTLE ----------------
    req1_a = 32'h12345678; req1_b = 32'hFFFFFFFF; req1_cmd = 3'd2; req1_valid = 1;
    #1;
    check_eq("rms_rdy1", {31'd0, req1_ready}, 32'd1);
    tick();                       // cycle 1
    req1_valid = 0;
    tick();                       // cycle 2
    reset = 1;
    req0_valid = 1;
    #1;
    check_eq("rms_opa", alu_operandA, 32'd0);
    check_eq("rms_opb", alu_operandB, 32'd0);
    check_eq("rms_cmd", {29'd0, alu_command}, 32'd0);
    check_eq("rms_rdy0", {31'd0, req0_ready}, 32'd0);
    req0_valid = 0;
    tick();
    reset = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      check_eq("rms_norsp", {31'd0, rsp_valid}, 32'd0);
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    check_eq("rms_tie0", {31'd0, req0_ready}, 32'd1);
    check_eq("rms_tie1", {31'd0, req1_ready}, 32'd0);
    req0_valid = 0; req1_valid = 0;
    tick();

    // ---------------- SETTLE_CYCLES=1 back-to-back ----------------
    s1_req0_a = 32'd0; s1_req0_b = 32'd0; s1_req0_cmd = 3'd6;
    s1_rsp_ready = 1; s1_req0_valid = 1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("s1_acc", {31'd0, s1_req0_ready}, 32'd1);
      tick();                     // cycle 1
      check_eq("s1_c1_rdy", {31'd0, s1_req0_ready}, 32'd0);
      check_eq("s1_c1_v", {31'd0, s1_rsp_valid}, 32'd0);
      tick();                     // cycle 2
      check_eq("s1_c2_v", {31'd0, s1_rsp_valid}, 32'd1);
      check_eq("s1_res", s1_rsp_result, 32'hFFFFFFFF);
      check_eq("s1_c2_rdy", {31'd0, s1_req0_ready}, 32'd0);
      tick();                     // back in IDLE
    end
    s1_req0_valid = 0; s1_rsp_ready = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
